// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - two-master arbiter in front of a single timer register port with owner-routed IRQ

module timer_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [1:0]  m0_addr,
    input  logic        m0_wen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_irq,

    input  logic        m1_req,
    input  logic [1:0]  m1_addr,
    input  logic        m1_wen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_irq,

    output logic [1:0]  t_addr,
    output logic        t_wen,
    output logic [31:0] t_wdata,
    input  logic [31:0] t_rdata,
    input  logic        t_irq
);

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        gnt_q;        // 0 = M0, 1 = M1
    logic        rr_last_q;
    logic        owner_q;

    logic        any_req;
    logic        gnt_d;
    logic [1:0]  sel_addr;
    logic        sel_wen;
    logic [31:0] sel_wdata;
    logic [31:0] rd_value;

    // Tie-break: fixed priority favours M0, otherwise the master not served last.
    always_comb begin
        any_req = m0_req | m1_req;
        gnt_d   = 1'b0;
        if (m0_req && m1_req) begin
            gnt_d = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last_q;
        end else if (m1_req) begin
            gnt_d = 1'b1;
        end
    end

    always_comb begin
        sel_addr  = m0_addr;
        sel_wen   = m0_wen;
        sel_wdata = m0_wdata;
        if (gnt_d) begin
            sel_addr  = m1_addr;
            sel_wen   = m1_wen;
            sel_wdata = m1_wdata;
        end
    end

    always_comb begin
        rd_value = t_rdata;
        if (t_addr == ADDR_RSVD) begin
            rd_value = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_addr    <= 2'd0;
            t_wen     <= 1'b0;
            t_wdata   <= 32'd0;
            gnt_q     <= 1'b0;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
            m0_irq    <= 1'b0;
            m1_irq    <= 1'b0;
        end else begin
            m0_irq <= t_irq & ~owner_q;
            m1_irq <= t_irq &  owner_q;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            t_wen  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q     <= gnt_d;
                        rr_last_q <= gnt_d;
                        t_addr    <= sel_addr;
                        t_wdata   <= sel_wdata;
                        t_wen     <= sel_wen && (sel_addr != ADDR_RSVD);
                    end
                end
                S_ACCESS: begin
                    // The timer write commits on this same edge, so t_wen doubles as "real write".
                    if (gnt_q) begin
                        m1_rdata <= rd_value;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_rdata <= rd_value;
                        m0_ack   <= 1'b1;
                    end
                    if (t_wen && (t_addr == ADDR_CTRL)) begin
                        owner_q <= gnt_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
